// File: rtl/io_config_pkg.sv
// Shared sizing and state encoding for the IO-line configuration loader.
package io_config_pkg;

  localparam int CONFIG_WIDTH      = 72;
  localparam int TILE_CONFIG_WIDTH = 24;
  localparam int NUM_TILES         = CONFIG_WIDTH / TILE_CONFIG_WIDTH;
  localparam int WORD_WIDTH        = 8;
  localparam int NUM_WORDS         = CONFIG_WIDTH / WORD_WIDTH;
  localparam int COUNT_W           = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } loader_state_e;

endpackage

// File: rtl/config_shadow_reg.sv
// Shadow register for an in-flight bitstream: word index, assembled image and running XOR.
module config_shadow_reg
  import io_config_pkg::*;
(
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    clear_i,
  input  logic                    wr_i,
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic [CONFIG_WIDTH-1:0] shadow_o,
  output logic                    last_word_o,
  output logic [WORD_WIDTH-1:0]   checksum_o
);

  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic [WORD_WIDTH-1:0]   csum_q, csum_d;

  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    csum_d   = csum_q;
    if (clear_i) begin
      shadow_d = '0;
      count_d  = '0;
      csum_d   = '0;
    end else if (wr_i) begin
      // Word k lands at [k*W +: W] so tile 0 is filled first.
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (count_q == COUNT_W'(k)) shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = data_i;
      end
      count_d = count_q + COUNT_W'(1);
      csum_d  = csum_q ^ data_i;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shadow_q <= '0;
      count_q  <= '0;
      csum_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
    end
  end

  assign shadow_o    = shadow_q;
  assign last_word_o = (count_q == COUNT_W'(NUM_WORDS - 1));
  assign checksum_o  = csum_q;

endmodule

// File: rtl/io_line_config_loader.sv
// Loads a checksummed bitstream into a shadow and commits it atomically to config_out.
//   state | meaning
//   IDLE  | waiting for start; config_out holds last good image
//   LOAD  | accepting data words into the shadow
//   CHECK | accepting the single trailing checksum word
module io_line_config_loader
  import io_config_pkg::*;
(
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WORD_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  loader_state_e state_q, state_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic clear, wr, last_word, xfer;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic [WORD_WIDTH-1:0]   checksum;

  config_shadow_reg u_shadow (
    .clock       (clock),
    .nreset      (nreset),
    .clear_i     (clear),
    .wr_i        (wr),
    .data_i      (s_data),
    .shadow_o    (shadow),
    .last_word_o (last_word),
    .checksum_o  (checksum)
  );

  assign s_ready = ((state_q == LOAD) || (state_q == CHECK)) && !abort;
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    error_d = error_q;
    clear   = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          clear   = 1'b1;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (xfer) begin
          wr = 1'b1;
          if (last_word) state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (xfer) begin
          state_d = IDLE;
          if (s_data == checksum) begin
            cfg_d   = shadow;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign config_out   = cfg_q;
  assign config_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_io_line_config_loader.sv
// Directed bench: stimulus pushes expected load outcomes, a monitor checks them when busy falls.
module tb_io_line_config_loader;
  import io_config_pkg::*;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [WORD_WIDTH-1:0] s_data = '0;
  logic s_ready, config_valid, busy, done, error;
  logic [CONFIG_WIDTH-1:0] config_out;

  io_line_config_loader dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .config_out(config_out), .config_valid(config_valid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                    done;
    logic                    error;
    logic [CONFIG_WIDTH-1:0] cfg;
    logic                    valid;
  } outcome_t;

  outcome_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [CONFIG_WIDTH-1:0] IMG_A = 72'h090807060504030201;
  localparam logic [CONFIG_WIDTH-1:0] IMG_B = 72'h181716151413121110;

  task automatic chk(input string name, input logic [CONFIG_WIDTH-1:0] act,
                     input logic [CONFIG_WIDTH-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: a load ends whenever busy falls; compare against the oldest expectation.
  initial begin
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    outcome_t e;
    forever begin
      @(negedge clock);
      if (!nreset) begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_one_cycle", {71'd0, done}, 72'd0);
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_outcome: got done=%b error=%b expected none", done, error);
          end else begin
            e = exp_q.pop_front();
            chk("out_done",  {71'd0, done},  {71'd0, e.done});
            chk("out_error", {71'd0, error}, {71'd0, e.error});
            chk("out_cfg",   config_out,     e.cfg);
            chk("out_valid", {71'd0, config_valid}, {71'd0, e.valid});
          end
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_WIDTH-1:0] d, input int gap);
    logic r;
    int n;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1; s_data = d;
    n = 0;
    forever begin
      @(negedge clock); r = s_ready;
      tick();
      if (r) break;
      if (++n > 50) begin
        n_vec++; n_err++;
        $display("FAIL handshake_timeout: got s_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_image(input logic [CONFIG_WIDTH-1:0] img,
                            input logic [WORD_WIDTH-1:0] csum, input int max_gap);
    for (int k = 0; k < NUM_WORDS; k++)
      send_word(img[k*WORD_WIDTH +: WORD_WIDTH], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    send_word(csum, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  initial begin
    // 1 reset
    #12;
    chk("rst_cfg",   config_out, '0);
    chk("rst_valid", {71'd0, config_valid}, 72'd0);
    chk("rst_busy",  {71'd0, busy},  72'd0);
    chk("rst_done",  {71'd0, done},  72'd0);
    chk("rst_error", {71'd0, error}, 72'd0);
    chk("rst_ready", {71'd0, s_ready}, 72'd0);
    @(negedge clock); nreset = 1'b1;
    tick();

    // 2 good load
    exp_q.push_back('{done: 1'b1, error: 1'b0, cfg: IMG_A, valid: 1'b1});
    do_start();
    send_image(IMG_A, 8'h01, 0);
    repeat (3) tick();

    // 3 bad checksum
    exp_q.push_back('{done: 1'b0, error: 1'b1, cfg: IMG_A, valid: 1'b1});
    do_start();
    send_image(IMG_A, 8'h00, 0);
    repeat (3) tick();
    chk("err_sticky", {71'd0, error}, 72'd1);

    // abort together with start in IDLE: neither takes effect
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("idle_abort_busy", {71'd0, busy}, 72'd0);
    tick();

    // 4 backpressure
    exp_q.push_back('{done: 1'b1, error: 1'b0, cfg: IMG_B, valid: 1'b1});
    do_start();
    @(negedge clock);
    chk("start_clears_err", {71'd0, error}, 72'd0);
    send_image(IMG_B, 8'h18, 3);
    repeat (3) tick();
    exp_q.push_back('{done: 1'b1, error: 1'b0, cfg: IMG_A, valid: 1'b1});
    do_start();
    send_image(IMG_A, 8'h01, 3);
    repeat (3) tick();

    // 5 abort after 4 words, then a good load
    exp_q.push_back('{done: 1'b0, error: 1'b1, cfg: IMG_A, valid: 1'b1});
    do_start();
    for (int k = 0; k < 4; k++) send_word(IMG_B[k*WORD_WIDTH +: WORD_WIDTH], 0);
    s_valid = 1'b1; s_data = 8'h55; abort = 1'b1;
    @(negedge clock);
    chk("abort_ready", {71'd0, s_ready}, 72'd0);
    tick(); abort = 1'b0; s_valid = 1'b0;
    repeat (2) tick();
    exp_q.push_back('{done: 1'b1, error: 1'b0, cfg: IMG_B, valid: 1'b1});
    do_start();
    send_image(IMG_B, 8'h18, 1);
    repeat (3) tick();

    // 6 async reset mid-load
    do_start();
    for (int k = 0; k < 5; k++) send_word(IMG_A[k*WORD_WIDTH +: WORD_WIDTH], 0);
    #3 nreset = 1'b0;
    #1;
    chk("mid_rst_cfg",   config_out, '0);
    chk("mid_rst_valid", {71'd0, config_valid}, 72'd0);
    chk("mid_rst_busy",  {71'd0, busy}, 72'd0);
    @(negedge clock);
    @(posedge clock); #1 nreset = 1'b1;
    tick();
    exp_q.push_back('{done: 1'b1, error: 1'b0, cfg: IMG_A, valid: 1'b1});
    do_start();
    send_image(IMG_A, 8'h01, 0);
    repeat (4) tick();

    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule
